rf: RTL and testbench
=====================

# rf

Integer register file feeding the execute stage of the single-cycle RV32I hart. It holds x0–x31 and serves two combinational read ports whose data drives the ALU operands `i_op1` and `i_op2`, either directly or through the operand muxes. It also accepts one synchronous write per cycle from writeback (ALU result, load data or link address). x0 reads as zero and ignores writes; an optional write-through bypass serves pipelined derivatives of the core.

## Interface
- `BYPASS`, default 0: 1 means a read of the register being written this cycle returns `i_rd_wdata`. Must stay 0 in the single-cycle core, because there wdata depends combinationally on the read data.
- `RESET_VAL`, default 32'h0: value loaded into x1–x31 on reset.
- `i_clk` input 1: sole clock, rising-edge.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_rs1_raddr` input 5: read port 1 address.
- `o_rs1_rdata` output 32: read port 1 data, toward ALU `i_op1`.
- `i_rs2_raddr` input 5: read port 2 address.
- `o_rs2_rdata` output 32: read port 2 data, toward ALU `i_op2` or store data.
- `i_rd_wen` input 1: write enable.
- `i_rd_waddr` input 5: write address.
- `i_rd_wdata` input 32: write data.

## Operation
- Storage is 31 × 32-bit flops for x1–x31. x0 has no storage; reads of address 0 return 32'h0 on both ports regardless of `BYPASS`.
- Write happens when `i_rd_wen`=1, `i_rd_waddr`≠0 and `i_rst_n`=1 at the rising edge of `i_clk`. The register takes `i_rd_wdata`. No other register changes.
- A write with `i_rd_waddr`=0 is discarded with no side effect.
- Reads are purely combinational from the addresses. Both ports are independent and may address the same register.
- With `BYPASS`=1, if `i_rd_wen` is set, `i_rd_waddr`≠0 and the read address equals `i_rd_waddr`, that port returns `i_rd_wdata`. Otherwise it returns the stored value.
- With `BYPASS`=0, a read in the write cycle returns the old value; the new value is visible right after the edge.
- Reset: when `i_rst_n` falls, all x1–x31 take `RESET_VAL` immediately, without waiting for a clock edge. Reads reflect this combinationally. Writes are blocked while reset is low.
- No X may propagate from storage: every register has a defined reset value.

## Timing
- Read latency is 0 cycles, combinational address-to-data. Write latency is 1 edge.
- Reset values: `o_rs1_rdata` and `o_rs2_rdata` read `RESET_VAL`, or 0 for address 0, as soon as `i_rst_n`=0.
- Reset deasserted at the same instant as a clock edge: that edge performs no write. The first write takes effect on the next edge with `i_rst_n`=1 sampled high.
- Reset asserted mid-cycle while `i_rd_wen`=1: the pending write is lost and the register holds `RESET_VAL`.
- Back-to-back writes to the same register on consecutive edges: the last one wins, and each value is readable for one cycle.
- Critical path (single-cycle core): raddr decode → 32:1 mux → ALU → writeback mux → `i_rd_wdata` flop D.

## Structure
- Shared package `rv_pkg` holds the constants `XLEN`=32, `REG_ADDR_W`=5 and `REG_COUNT`=32. The ALU and decoder import the same constants.
- No sub-module. Use a flat register array with a generate loop over x1–x31 and one read-mux function reused for both ports.

## Test plan
- Reset: hold `i_rst_n`=0 and sweep the rs1/rs2 addresses 0–31. Required: every read returns 0 (default `RESET_VAL`), with no X on either port.
- Basic write and read: write x1=32'h5, then x2=32'h6, then read rs1=1, rs2=2. Required: 32'h5 and 32'h6. Feeding the ALU with i_opsel=000, i_sub=1 gives 32'hFFFFFFFF.
- x0 protection: write x0=32'hDEADBEEF, then read rs1=0, rs2=0. Required: 0 on both ports.
- Same-cycle read-during-write to x3 (32'h00000003 to 32'hFFFFFFFB): with `BYPASS`=0, the old value 32'h3 is returned before the edge and 32'hFFFFFFFB after it. With `BYPASS`=1, 32'hFFFFFFFB is returned in the same cycle.
- Async reset mid-operation: after x5=32'h1234, pull `i_rst_n` low between clock edges. Required: x5 reads 0 immediately. A write asserted during reset is ignored, and the first write after release lands on the next edge.
- Dual port, same address: rs1=rs2=31 after writing 32'h80000000. Required: both ports return 32'h80000000. Randomised writes are then checked against a reference array model for 1000 cycles.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I architectural constants used by the register file, ALU and decoder.
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;

endpackage : rv_pkg

// File: rtl/rf.sv
// Integer register file x0-x31: two combinational read ports, one synchronous
// write port. x0 has no storage and always reads zero. The optional bypass
// forwards same-cycle write data to a matching read port. It must stay off in the
// single-cycle core, where write data depends combinationally on the read data.
module rf
    import rv_pkg::*;
#(
    parameter bit              BYPASS    = 1'b0,
    parameter logic [XLEN-1:0] RESET_VAL = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [REG_ADDR_W-1:0] i_rs1_raddr,
    output logic [XLEN-1:0]       o_rs1_rdata,
    input  logic [REG_ADDR_W-1:0] i_rs2_raddr,
    output logic [XLEN-1:0]       o_rs2_rdata,
    input  logic                  i_rd_wen,
    input  logic [REG_ADDR_W-1:0] i_rd_waddr,
    input  logic [XLEN-1:0]       i_rd_wdata
);

    logic [XLEN-1:0] regs_q [1:REG_COUNT-1];

    // Write to x0 is dropped here, so the per-register decode never matches it.
    logic wr_live;
    assign wr_live = i_rd_wen && (i_rd_waddr != '0);

    for (genvar i = 1; i < REG_COUNT; i++) begin : g_reg
        logic wr_hit_d;
        assign wr_hit_d = wr_live && (i_rd_waddr == REG_ADDR_W'(i));

        // One storage register: async reset to RESET_VAL, load on decoded write.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                regs_q[i] <= RESET_VAL;
            end else if (wr_hit_d) begin
                regs_q[i] <= i_rd_wdata;
            end
        end
    end

    // Shared read mux for both ports. The bypass is gated by reset so that reads
    // show RESET_VAL for the whole time reset is low.
    function automatic logic [XLEN-1:0] rd_mux(input logic [REG_ADDR_W-1:0] raddr);
        logic [XLEN-1:0] data;
        data = '0;
        if (raddr != '0) begin
            if (BYPASS && i_rst_n && wr_live && (raddr == i_rd_waddr)) begin
                data = i_rd_wdata;
            end else begin
                data = regs_q[raddr];
            end
        end
        return data;
    endfunction

    // Read port 1, combinational from address.
    always_comb begin
        o_rs1_rdata = rd_mux(i_rs1_raddr);
    end

    // Read port 2, combinational from address.
    always_comb begin
        o_rs2_rdata = rd_mux(i_rs2_raddr);
    end

endmodule : rf

// File: tb/tb_rf.sv
// Directed and random checks of rf, with one instance built without the bypass
// (u_rf0) and one built with it (u_rf1). Both instances share all inputs.
module tb_rf;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_a, rs2_a, wa;
    logic        wen;
    logic [31:0] wd;
    logic [31:0] rs1_0, rs2_0, rs1_1, rs2_1;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] model [32];

    rf #(.BYPASS(1'b0)) u_rf0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rs1_raddr(rs1_a), .o_rs1_rdata(rs1_0),
        .i_rs2_raddr(rs2_a), .o_rs2_rdata(rs2_0),
        .i_rd_wen(wen), .i_rd_waddr(wa), .i_rd_wdata(wd)
    );

    rf #(.BYPASS(1'b1)) u_rf1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rs1_raddr(rs1_a), .o_rs1_rdata(rs1_1),
        .i_rs2_raddr(rs2_a), .o_rs2_rdata(rs2_1),
        .i_rd_wen(wen), .i_rd_waddr(wa), .i_rd_wdata(wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One full write cycle: drive at the falling edge, commit at the rising edge.
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wen = 1'b1; wa = a; wd = d;
        @(posedge clk);
        #1 wen = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        rs1_a = a1; rs2_a = a2;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; wen = 1'b0; wa = '0; wd = '0; rs1_a = '0; rs2_a = '0;

        // Reset sweep: every address reads zero on both ports, no X.
        #2;
        for (int a = 0; a < 32; a++) begin
            rd(5'(a), 5'(31 - a));
            chk("rst_rs1", rs1_0, 32'h0);
            chk("rst_rs2", rs2_0, 32'h0);
            chk("rst_rs1_byp", rs1_1, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write and read.
        wr(5'd1, 32'h5);
        wr(5'd2, 32'h6);
        rd(5'd1, 5'd2);
        chk("x1", rs1_0, 32'h5);
        chk("x2", rs2_0, 32'h6);
        chk("alu_sub", rs1_0 - rs2_0, 32'hFFFF_FFFF);

        // x0 protection, including the bypass instance during the write cycle.
        @(negedge clk);
        wen = 1'b1; wa = 5'd0; wd = 32'hDEAD_BEEF;
        rd(5'd0, 5'd0);
        chk("x0_byp_rs1", rs1_1, 32'h0);
        chk("x0_byp_rs2", rs2_1, 32'h0);
        @(posedge clk);
        #1 wen = 1'b0;
        rd(5'd0, 5'd0);
        chk("x0_rs1", rs1_0, 32'h0);
        chk("x0_rs2", rs2_0, 32'h0);
        rd(5'd1, 5'd2);
        chk("x0_no_side_x1", rs1_0, 32'h5);
        chk("x0_no_side_x2", rs2_0, 32'h6);

        // Read-during-write to x3.
        wr(5'd3, 32'h3);
        @(negedge clk);
        wen = 1'b1; wa = 5'd3; wd = 32'hFFFF_FFFB;
        rd(5'd3, 5'd3);
        chk("rdw_old", rs1_0, 32'h3);
        chk("rdw_byp", rs1_1, 32'hFFFF_FFFB);
        chk("rdw_byp_rs2", rs2_1, 32'hFFFF_FFFB);
        @(posedge clk);
        #1 wen = 1'b0;
        chk("rdw_new", rs1_0, 32'hFFFF_FFFB);

        // Async reset mid-operation, with a write pending during reset.
        wr(5'd5, 32'h1234);
        rd(5'd5, 5'd3);
        chk("x5_pre", rs1_0, 32'h1234);
        @(negedge clk);
        wen = 1'b1; wa = 5'd5; wd = 32'hAAAA_AAAA;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_x5", rs1_0, 32'h0);
        chk("rst_async_x3", rs2_0, 32'h0);
        chk("rst_async_byp", rs1_1, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_wr_blocked", rs1_0, 32'h0);
        chk("rst_wr_blocked_byp", rs1_1, 32'h0);
        @(negedge clk);
        wen = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        wen = 1'b1; wa = 5'd5; wd = 32'h0000_BEEF;
        #1;
        chk("post_rst_pre_edge", rs1_0, 32'h0);
        @(posedge clk);
        #1 wen = 1'b0;
        chk("post_rst_write", rs1_0, 32'h0000_BEEF);

        // Back-to-back writes to x10.
        rs1_a = 5'd10;
        @(negedge clk);
        wen = 1'b1; wa = 5'd10; wd = 32'h1;
        @(posedge clk);
        #1;
        chk("b2b_first", rs1_0, 32'h1);
        wd = 32'h2;
        @(posedge clk);
        #1 wen = 1'b0;
        chk("b2b_second", rs1_0, 32'h2);

        // Dual port same address.
        wr(5'd31, 32'h8000_0000);
        rd(5'd31, 5'd31);
        chk("dual_rs1", rs1_0, 32'h8000_0000);
        chk("dual_rs2", rs2_0, 32'h8000_0000);

        // Random phase against a reference array, starting from a fresh reset.
        @(negedge clk);
        rst_n = 1'b0;
        for (int r = 0; r < 32; r++) model[r] = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            logic [31:0] e1, e2;
            @(negedge clk);
            wen   = 1'($urandom_range(0, 1));
            wa    = 5'($urandom_range(0, 31));
            wd    = $urandom;
            rs1_a = 5'($urandom_range(0, 31));
            rs2_a = (c % 4 == 0) ? wa : 5'($urandom_range(0, 31));
            #1;
            chk("rnd_rs1", rs1_0, model[rs1_a]);
            chk("rnd_rs2", rs2_0, model[rs2_a]);
            e1 = (wen && wa != 5'd0 && rs1_a == wa) ? wd : model[rs1_a];
            e2 = (wen && wa != 5'd0 && rs2_a == wa) ? wd : model[rs2_a];
            chk("rnd_byp_rs1", rs1_1, e1);
            chk("rnd_byp_rs2", rs2_1, e2);
            @(posedge clk);
            if (wen && wa != 5'd0) model[wa] = wd;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_rf
